// File: rtl/fifo_pkg.sv
// Shared types, default sizing and helper functions for sync_fifo_ctrl.
// The optional FIFO_PARITY_EN build stores one extra even-parity bit per word.
package fifo_pkg;

   localparam int FIFO_WIDTH  = 8;
   localparam int FIFO_DEPTH  = 16;
   localparam int FIFO_ADDR_W = 4;
   localparam int FIFO_AF     = 14;
   localparam int FIFO_AE     = 2;

   // Pointer carries one wrap bit above the storage address.
   typedef logic [FIFO_ADDR_W:0] ptr_t;
   // Occupancy has to reach DEPTH, hence one extra bit.
   typedef logic [FIFO_ADDR_W:0] count_t;

   // Even parity bit: makes the total number of ones even.
   function automatic logic even_par(input logic [63:0] d);
      return ^d;
   endfunction

   // Threshold ordering must leave a gap between the two soft flags.
   function automatic bit levels_ok(input int ae, input int af, input int depth);
      return (ae < af) && (af <= depth);
   endfunction

   // Depth must be a power of two matching the address width.
   function automatic bit depth_ok(input int depth, input int aw);
      return (depth >= 4) && (depth == (1 << aw));
   endfunction

endpackage

// File: rtl/fifo_storage.sv
// Simple dual-port array: one write port, one registered read port.
// The array has no reset; only the read register clears.
module fifo_storage
   import fifo_pkg::*;
#(
   parameter int DW = FIFO_WIDTH,
   parameter int AW = FIFO_ADDR_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   localparam int N = 1 << AW;

   logic [DW-1:0] mem_q [N];
   logic [DW-1:0] rdata_q;

   // Write port: array contents survive reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // Read port: register updates only on a read, holds otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (re) begin
         rdata_q <= mem_q[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy, flags, error pulses.
// Define FIFO_PARITY_EN to store and check even parity per word.
module sync_fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int WIDTH    = FIFO_WIDTH,
   parameter int DEPTH    = FIFO_DEPTH,
   parameter int ADDR_W   = FIFO_ADDR_W,
   parameter int AF_LEVEL = FIFO_AF,
   parameter int AE_LEVEL = FIFO_AE
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              rd_en,
   output logic [WIDTH-1:0]  rd_data,
   output logic              rd_valid,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              underflow,
   output logic              parity_err
);

`ifdef FIFO_PARITY_EN
   localparam int SW = WIDTH + 1;
`else
   localparam int SW = WIDTH;
`endif

   typedef logic [ADDR_W:0] lptr_t;

   localparam lptr_t ONE   = lptr_t'(1);
   localparam lptr_t C_MAX = lptr_t'(DEPTH);
   localparam lptr_t C_AF  = lptr_t'(AF_LEVEL);
   localparam lptr_t C_AE  = lptr_t'(AE_LEVEL);

   if (!levels_ok(AE_LEVEL, AF_LEVEL, DEPTH) || !depth_ok(DEPTH, ADDR_W)) begin : g_bad_cfg
      $error("sync_fifo_ctrl: illegal DEPTH/ADDR_W/AE_LEVEL/AF_LEVEL");
   end

   lptr_t wr_ptr_q, wr_ptr_d;
   lptr_t rd_ptr_q, rd_ptr_d;
   lptr_t count_q,  count_d;
   logic  rd_valid_q, rd_valid_d;
   logic  ovf_q, ovf_d;
   logic  udf_q, udf_d;
   logic  push, pop;

   logic [SW-1:0] wdata;
   logic [SW-1:0] rdata;

   assign full         = (count_q == C_MAX);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= C_AF);
   assign almost_empty = (count_q <= C_AE);
   assign count        = count_q;
   assign rd_valid     = rd_valid_q;
   assign overflow     = ovf_q;
   assign underflow    = udf_q;

   // Accept decisions and next state, all from pre-edge occupancy.
   always_comb begin
      push       = wr_en & ~full;
      pop        = rd_en & ~empty;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      rd_valid_d = pop;
      ovf_d      = wr_en & full;
      udf_d      = rd_en & empty;
      if (push) begin
         wr_ptr_d = wr_ptr_q + ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + ONE;
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + ONE;
         2'b01:   count_d = count_q - ONE;
         default: count_d = count_q;
      endcase
   end

   // Control registers; reset wins over any request in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_valid_q <= 1'b0;
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rd_valid_q <= rd_valid_d;
         ovf_q      <= ovf_d;
         udf_q      <= udf_d;
      end
   end

   fifo_storage #(
      .DW (SW),
      .AW (ADDR_W)
   ) u_storage (
      .clk   (clk),
      .rst   (rst),
      .we    (push),
      .waddr (wr_ptr_q[ADDR_W-1:0]),
      .wdata (wdata),
      .re    (pop),
      .raddr (rd_ptr_q[ADDR_W-1:0]),
      .rdata (rdata)
   );

`ifdef FIFO_PARITY_EN
   assign wdata      = {even_par(64'(wr_data)), wr_data};
   assign rd_data    = rdata[WIDTH-1:0];
   assign parity_err = rd_valid_q &
                       (rdata[WIDTH] ^ even_par(64'(rdata[WIDTH-1:0])));
`else
   assign wdata      = wr_data;
   assign rd_data    = rdata;
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed self-checking bench for sync_fifo_ctrl.
// Build with FIFO_PARITY_EN to exercise the parity error path.
module tb_sync_fifo_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic       almost_empty;
   logic [4:0] count;
   logic       overflow;
   logic       underflow;
   logic       parity_err;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sync_fifo_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow),
      .parity_err   (parity_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock with the given requests; returns #1 after the edge.
   task automatic step(input logic w, input logic [7:0] d, input logic r);
      wr_en   = w;
      wr_data = d;
      rd_en   = r;
      @(posedge clk);
      #1;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
   endtask

   initial begin
      logic [7:0] q[$];
      logic [7:0] exp_d;
      logic [7:0] cnt_d;
      int         phase;

      rst     = 1'b1;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      wr_data = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      chk("rst_count", 32'(count), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_ae", 32'(almost_empty), 1);
      chk("rst_af", 32'(almost_full), 0);
      chk("rst_rdv", 32'(rd_valid), 0);
      chk("rst_rdd", 32'(rd_data), 0);
      chk("rst_ovf", 32'(overflow), 0);
      chk("rst_udf", 32'(underflow), 0);
      chk("rst_perr", 32'(parity_err), 0);

      // Fill 0x00..0x0F.
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 8'(i), 1'b0);
         chk("fill_count", 32'(count), 32'(i + 1));
         chk("fill_af", 32'(almost_full), 32'((i + 1) >= 14));
         chk("fill_ae", 32'(almost_empty), 32'((i + 1) <= 2));
         chk("fill_full", 32'(full), 32'(i == 15));
         chk("fill_ovf", 32'(overflow), 0);
      end

      // Push into a full FIFO.
      step(1'b1, 8'hAA, 1'b0);
      chk("ovf_pulse", 32'(overflow), 1);
      chk("ovf_count", 32'(count), 16);
      step(1'b0, 8'h00, 1'b0);
      chk("ovf_clear", 32'(overflow), 0);

      // Drain in order.
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 8'h00, 1'b1);
         chk("drain_rdv", 32'(rd_valid), 1);
         chk("drain_data", 32'(rd_data), 32'(i));
         chk("drain_count", 32'(count), 32'(15 - i));
      end
      chk("drain_empty", 32'(empty), 1);

      // Pop from empty.
      step(1'b0, 8'h00, 1'b1);
      chk("udf_pulse", 32'(underflow), 1);
      chk("udf_rdv", 32'(rd_valid), 0);
      chk("udf_hold", 32'(rd_data), 32'h0F);
      chk("udf_count", 32'(count), 0);

      // Simultaneous push+pop on empty.
      step(1'b1, 8'h55, 1'b1);
      chk("e_pp_udf", 32'(underflow), 1);
      chk("e_pp_count", 32'(count), 1);
      chk("e_pp_rdv", 32'(rd_valid), 0);
      step(1'b0, 8'h00, 1'b1);
      chk("e_pp_data", 32'(rd_data), 32'h55);
      chk("e_pp_rdv2", 32'(rd_valid), 1);
      chk("e_pp_udf2", 32'(underflow), 0);

      // Simultaneous push+pop on full.
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 8'(8'h80 + i), 1'b0);
      end
      chk("f_full", 32'(full), 1);
      step(1'b1, 8'h77, 1'b1);
      chk("f_pp_ovf", 32'(overflow), 1);
      chk("f_pp_count", 32'(count), 15);
      chk("f_pp_data", 32'(rd_data), 32'h80);
      chk("f_pp_rdv", 32'(rd_valid), 1);
      for (int i = 1; i < 16; i++) begin
         step(1'b0, 8'h00, 1'b1);
         chk("f_drain", 32'(rd_data), 32'(8'h80 + i));
      end
      chk("f_no77", 32'(empty), 1);

      // Interleaved traffic across the pointer wrap.
      cnt_d = 8'h10;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, cnt_d, 1'b0);
         q.push_back(cnt_d);
         cnt_d++;
      end
      for (int c = 0; c < 40; c++) begin
         phase = c % 3;
         if (phase == 0) begin
            step(1'b1, cnt_d, 1'b0);
            q.push_back(cnt_d);
            cnt_d++;
         end else if (phase == 1) begin
            exp_d = q.pop_front();
            step(1'b0, 8'h00, 1'b1);
            chk("wrap_pop", 32'(rd_data), 32'(exp_d));
         end else begin
            exp_d = q.pop_front();
            step(1'b1, cnt_d, 1'b1);
            q.push_back(cnt_d);
            cnt_d++;
            chk("wrap_pp", 32'(rd_data), 32'(exp_d));
         end
         chk("wrap_count", 32'(count), 32'(q.size()));
         chk("wrap_le5", 32'(count <= 5'd5), 1);
      end
      while (q.size() > 0) begin
         exp_d = q.pop_front();
         step(1'b0, 8'h00, 1'b1);
         chk("wrap_tail", 32'(rd_data), 32'(exp_d));
      end
      chk("wrap_empty", 32'(empty), 1);

      // Reset during push+pop with 9 entries.
      for (int i = 0; i < 9; i++) begin
         step(1'b1, 8'(8'hC0 + i), 1'b0);
      end
      chk("pre_rst_cnt", 32'(count), 9);
      rst = 1'b1;
      step(1'b1, 8'hEE, 1'b1);
      rst = 1'b0;
      chk("mid_rst_cnt", 32'(count), 0);
      chk("mid_rst_emp", 32'(empty), 1);
      chk("mid_rst_rdv", 32'(rd_valid), 0);
      step(1'b1, 8'h3C, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      chk("post_rst_d", 32'(rd_data), 32'h3C);
      chk("post_rst_v", 32'(rd_valid), 1);

      // Parity path: words land at addresses 1 and 2 after the reset.
      step(1'b1, 8'h5A, 1'b0);
      step(1'b1, 8'h33, 1'b0);
`ifdef FIFO_PARITY_EN
      dut.u_storage.mem_q[1][0] = ~dut.u_storage.mem_q[1][0];
      step(1'b0, 8'h00, 1'b1);
      chk("par_data", 32'(rd_data), 32'h5B);
      chk("par_err", 32'(parity_err), 1);
`else
      step(1'b0, 8'h00, 1'b1);
      chk("par_data", 32'(rd_data), 32'h5A);
      chk("par_off", 32'(parity_err), 0);
`endif
      chk("par_rdv", 32'(rd_valid), 1);
      step(1'b0, 8'h00, 1'b1);
      chk("par_ok_d", 32'(rd_data), 32'h33);
      chk("par_ok_e", 32'(parity_err), 0);
      step(1'b0, 8'h00, 1'b0);
      chk("par_idle", 32'(parity_err), 0);
      chk("par_idlev", 32'(rd_valid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
